// File: rtl/lif_neuron_n.sv
// Leaky integrate-and-fire neuron with N_IN synapses.
// A step is accepted over a valid/ready handshake, its weighted sum is
// accumulated serially (one synapse per cycle), then leak, saturating
// membrane update, threshold firing and a refractory period follow.
module lif_neuron_n #(
    parameter int WIDTH      = 8,
    parameter int N_IN       = 4,
    parameter int V_W        = 16,
    parameter int V_TH       = 10,
    parameter int V_RESET    = 0,
    parameter int LEAK_SHIFT = 4,
    parameter int REFRAC     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       step_valid,
    output logic                       step_ready,
    input  logic [N_IN*WIDTH-1:0]      weight,
    input  logic [N_IN*WIDTH-1:0]      data,
    output logic                       spike,
    output logic                       step_done,
    output logic signed [V_W-1:0]      sum,
    output logic signed [V_W-1:0]      v_mem,
    output logic                       refrac_active
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CNT_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    // Two guard bits: enough headroom for v - leak + acc before clamping.
    localparam int G_W   = V_W + 2;

    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(N_IN - 1);
    localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'(REFRAC);
    localparam logic signed [V_W-1:0] TH       = V_W'(V_TH);
    localparam logic signed [V_W-1:0] V_RST    = V_W'(V_RESET);
    localparam logic signed [G_W-1:0] V_MAX    = {2'b00, 1'b0, {(V_W-1){1'b1}}};
    localparam logic signed [G_W-1:0] V_MIN    = {2'b11, 1'b1, {(V_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_FIRE,
        S_REFRAC
    } state_t;

    state_t state, state_next;

    logic [N_IN*WIDTH-1:0]     w_q;
    logic [N_IN*WIDTH-1:0]     d_q;
    logic signed [V_W-1:0]     acc;
    logic [IDX_W-1:0]          idx;
    logic [CNT_W-1:0]          cnt;

    logic                      accept;
    logic signed [WIDTH-1:0]   w_cur;
    logic signed [WIDTH-1:0]   d_cur;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [V_W-1:0]     acc_next;
    logic signed [V_W-1:0]     leak;
    logic signed [V_W-1:0]     v_next;
    logic                      fire_hit;

    function automatic logic signed [V_W-1:0] sat_v(input logic signed [G_W-1:0] x);
        if (x > V_MAX) begin
            return V_MAX[V_W-1:0];
        end else if (x < V_MIN) begin
            return V_MIN[V_W-1:0];
        end else begin
            return x[V_W-1:0];
        end
    endfunction

    assign accept = step_valid && step_ready;

    // Datapath arithmetic: current product, next accumulator and next membrane value.
    always_comb begin
        w_cur    = w_q[idx*WIDTH +: WIDTH];
        d_cur    = d_q[idx*WIDTH +: WIDTH];
        prod     = (2*WIDTH)'(w_cur) * (2*WIDTH)'(d_cur);
        acc_next = sat_v(G_W'(acc) + G_W'(prod));
        if (LEAK_SHIFT > 0) begin
            leak = v_mem >>> LEAK_SHIFT;
        end else begin
            leak = '0;
        end
        v_next   = sat_v(G_W'(v_mem) - G_W'(leak) + G_W'(acc));
        fire_hit = (v_next >= TH);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (idx == IDX_LAST) begin
                    state_next = S_FIRE;
                end
            end
            S_FIRE: begin
                if (fire_hit && (REFRAC > 0)) begin
                    state_next = S_REFRAC;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_REFRAC: begin
                if (accept && (cnt == CNT_W'(1))) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs; ready depends only on state and enable.
    always_comb begin
        step_ready    = en && ((state == S_IDLE) || (state == S_REFRAC));
        refrac_active = (state == S_REFRAC);
    end

    // Registered datapath: operand latch, accumulation, membrane update, pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_q       <= '0;
            d_q       <= '0;
            acc       <= '0;
            idx       <= '0;
            cnt       <= '0;
            v_mem     <= V_RST;
            sum       <= '0;
            spike     <= 1'b0;
            step_done <= 1'b0;
        end else begin
            spike     <= 1'b0;
            step_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        w_q <= weight;
                        d_q <= data;
                        acc <= '0;
                        idx <= '0;
                    end
                end
                S_ACCUM: begin
                    acc <= acc_next;
                    idx <= idx + IDX_W'(1);
                end
                S_FIRE: begin
                    sum       <= acc;
                    step_done <= 1'b1;
                    if (fire_hit) begin
                        v_mem <= V_RST;
                        spike <= 1'b1;
                        cnt   <= CNT_INIT;
                    end else begin
                        v_mem <= v_next;
                    end
                end
                S_REFRAC: begin
                    if (accept) begin
                        sum       <= '0;
                        step_done <= 1'b1;
                        cnt       <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
